// File: rtl/bus_mailbox_pkg.sv
// -----------------------------------------------------------------------------
// bus_mailbox_pkg
//   Shared definitions for the arilla bus mailbox target: register offsets
//   within the 4-word window, STATUS/CONTROL bit positions and the packed
//   layouts of the stored control bits and sticky error flags.
// -----------------------------------------------------------------------------
package bus_mailbox_pkg;

    // Word offsets inside the claimed 4-word window (address[1:0]).
    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_CONTROL  = 2'd2;
    localparam logic [1:0] REG_RESERVED = 2'd3;

    // STATUS bit positions.
    localparam int STAT_TX_EMPTY     = 0;
    localparam int STAT_TX_FULL      = 1;
    localparam int STAT_RX_EMPTY     = 2;
    localparam int STAT_RX_FULL      = 3;
    localparam int STAT_TX_OVERFLOW  = 4;
    localparam int STAT_RX_UNDERFLOW = 5;
    localparam int STAT_TX_COUNT_LSB = 8;
    localparam int STAT_RX_COUNT_LSB = 16;

    // CONTROL bit positions (all inside byte lane 0).
    localparam int CTRL_TX_FLUSH  = 0;
    localparam int CTRL_RX_FLUSH  = 1;
    localparam int CTRL_CLEAR     = 2;
    localparam int CTRL_RX_IRQ_EN = 3;
    localparam int CTRL_TX_IRQ_EN = 4;

    // Stored (non-pulse) CONTROL bits.
    typedef struct packed {
        logic tx_irq_en;
        logic rx_irq_en;
    } ctrl_reg_t;

    // Sticky error flags, cleared only by the CONTROL clear pulse or reset.
    typedef struct packed {
        logic rx_underflow;
        logic tx_overflow;
    } sticky_t;

endpackage

// File: rtl/arilla_bus_if.sv
// -----------------------------------------------------------------------------
// arilla_bus_if
//   Word-addressed arilla bus. The master drives address, byte_enable, read,
//   write and data_ctp (controller-to-peripheral). A target drives hit and
//   data_ptc (peripheral-to-controller) only while it owns the cycle and
//   releases them to 'z otherwise, so several targets may share the nets.
//   Modports: master (bus controller side), slave (target side).
// -----------------------------------------------------------------------------
interface arilla_bus_if #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 32
);
    logic [AddrWidth-1:0]   address;
    logic [DataWidth/8-1:0] byte_enable;
    logic                   read;
    logic                   write;
    logic [DataWidth-1:0]   data_ctp;
    wire                    hit;
    wire  [DataWidth-1:0]   data_ptc;

    modport master (
        output address, byte_enable, read, write, data_ctp,
        input  hit, data_ptc
    );

    modport slave (
        input  address, byte_enable, read, write, data_ctp,
        output hit, data_ptc
    );
endinterface

// File: rtl/bus_mailbox_target_fifo.sv
// -----------------------------------------------------------------------------
// mailbox_fifo
//   Synchronous FIFO of Depth words (Depth need not be a power of two).
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     i_push       write i_data when not full (ignored when full)
//     i_pop        advance the head when not empty (ignored when empty)
//     i_flush      empty the FIFO; overrides a same-cycle push/pop
//     i_data       word to push
//     o_data       current head word (valid while !o_empty)
//     o_full       count == Depth
//     o_empty      count == 0
//     o_count      occupancy, 0..Depth
// -----------------------------------------------------------------------------
module mailbox_fifo #(
    parameter int Depth     = 8,
    parameter int DataWidth = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [DataWidth-1:0]         i_data,
    output logic [DataWidth-1:0]         o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(Depth+1)-1:0]   o_count
);
    localparam int CountWidth = $clog2(Depth + 1);
    localparam int PtrWidth   = $clog2(Depth);

    logic [DataWidth-1:0]  r_mem [Depth];
    logic [PtrWidth-1:0]   r_wr_ptr;
    logic [PtrWidth-1:0]   r_rd_ptr;
    logic [CountWidth-1:0] r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // Pointers wrap at Depth, not at a power of two.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign o_full    = (r_count == CountWidth'(Depth));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full && !i_flush;
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;

    // NOTE: storage has no reset; the pointers and count alone define which
    // entries are valid, so clearing the array would only cost reset fanout.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: all clocked state uses <= so every flop samples pre-edge values
    // regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CountWidth'(1);
                2'b01:   r_count <= r_count - CountWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_mailbox_target.sv
// -----------------------------------------------------------------------------
// bus_mailbox_target
//   Arilla bus target claiming a 4-word window at BaseAddress (word address,
//   multiple of 4). Bus writes to DATA feed the TX stream through a FIFO; the
//   RX stream feeds bus reads of DATA through a second FIFO. STATUS reports
//   FIFO levels and sticky errors, CONTROL flushes, clears and enables irq.
//   DataWidth and AddrWidth must match the connected arilla_bus_if.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     bus_interface   arilla_bus_if.slave (hit and data_ptc are 'z when idle)
//     tx_data/valid   TX FIFO head / non-empty; popped on tx_valid && tx_ready
//     tx_ready        TX consumer ready
//     rx_data/valid   RX producer word / offer; pushed on rx_valid && rx_ready
//     rx_ready        RX FIFO not full
//     irq             registered level interrupt
// -----------------------------------------------------------------------------
module bus_mailbox_target
    import bus_mailbox_pkg::*;
#(
    parameter int BaseAddress = 0,
    parameter int Depth       = 8,
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arilla_bus_if.slave          bus_interface,
    output logic [DataWidth-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [DataWidth-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 irq
);
    localparam int                   BytesPerWord = DataWidth / 8;
    localparam int                   CountWidth   = $clog2(Depth + 1);
    localparam logic [AddrWidth-1:0] BaseWord     = AddrWidth'(BaseAddress);

    // Decode
    logic                  w_sel;
    logic [1:0]            w_offset;
    logic                  w_rd;
    logic                  w_wr;
    logic [DataWidth-1:0]  w_lane_mask;
    logic                  w_ctrl_wr;

    // FIFO controls and state
    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic                  w_tx_flush;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [CountWidth-1:0] w_tx_count;
    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic                  w_rx_flush;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic [CountWidth-1:0] w_rx_count;
    logic [DataWidth-1:0]  w_rx_head;

    // Register file
    logic                  w_clear;
    logic                  w_tx_ovf_set;
    logic                  w_rx_unf_set;
    logic [DataWidth-1:0]  w_status;
    logic [DataWidth-1:0]  w_rd_word;
    logic [DataWidth-1:0]  r_rdata;
    logic                  r_resp_valid;
    ctrl_reg_t             r_ctrl;
    sticky_t               r_sticky;
    logic                  r_irq;

    // ---------------------------------------------------------------- decode
    assign w_sel    = (bus_interface.address[AddrWidth-1:2] == BaseWord[AddrWidth-1:2]);
    assign w_offset = bus_interface.address[1:0];
    assign w_rd     = bus_interface.read && w_sel;
    assign w_wr     = bus_interface.write && w_sel;

    assign bus_interface.hit      = w_sel ? 1'b1 : 1'bz;
    // The read response is only driven in the cycle after the read.
    assign bus_interface.data_ptc = r_resp_valid ? r_rdata : {DataWidth{1'bz}};

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < BytesPerWord; i++) begin
            w_lane_mask[i*8 +: 8] = {8{bus_interface.byte_enable[i]}};
        end
    end

    // CONTROL bits only take effect when byte lane 0 is enabled.
    assign w_ctrl_wr  = w_wr && (w_offset == REG_CONTROL) && bus_interface.byte_enable[0];
    assign w_tx_flush = w_ctrl_wr && bus_interface.data_ctp[CTRL_TX_FLUSH];
    assign w_rx_flush = w_ctrl_wr && bus_interface.data_ctp[CTRL_RX_FLUSH];
    assign w_clear    = w_ctrl_wr && bus_interface.data_ctp[CTRL_CLEAR];

    // ----------------------------------------------------------------- FIFOs
    // Overflow is judged on the pre-edge full flag, so a same-cycle stream
    // pop does not make room for the incoming word.
    assign w_tx_push    = w_wr && (w_offset == REG_DATA);
    assign w_tx_pop     = !w_tx_empty && tx_ready;
    assign w_tx_ovf_set = w_tx_push && w_tx_full;

    // A same-cycle stream push cannot satisfy a read of an empty RX FIFO.
    assign w_rx_push    = rx_valid && !w_rx_full;
    assign w_rx_pop     = w_rd && (w_offset == REG_DATA);
    assign w_rx_unf_set = w_rx_pop && w_rx_empty;

    mailbox_fifo #(
        .Depth     (Depth),
        .DataWidth (DataWidth)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_flush (w_tx_flush),
        .i_data  (bus_interface.data_ctp & w_lane_mask),
        .o_data  (tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    mailbox_fifo #(
        .Depth     (Depth),
        .DataWidth (DataWidth)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .i_data  (rx_data),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    assign tx_valid = !w_tx_empty;
    assign rx_ready = !w_rx_full;

    // ------------------------------------------------------------ read mux
    always_comb begin
        w_status                                 = '0;
        w_status[STAT_TX_EMPTY]                  = w_tx_empty;
        w_status[STAT_TX_FULL]                   = w_tx_full;
        w_status[STAT_RX_EMPTY]                  = w_rx_empty;
        w_status[STAT_RX_FULL]                   = w_rx_full;
        w_status[STAT_TX_OVERFLOW]               = r_sticky.tx_overflow;
        w_status[STAT_RX_UNDERFLOW]              = r_sticky.rx_underflow;
        w_status[STAT_TX_COUNT_LSB +: 8]         = 8'(w_tx_count);
        w_status[STAT_RX_COUNT_LSB +: 8]         = 8'(w_rx_count);
    end

    always_comb begin
        w_rd_word = '0;
        case (w_offset)
            REG_DATA:    w_rd_word = w_rx_empty ? '0 : w_rx_head;
            REG_STATUS:  w_rd_word = w_status;
            REG_CONTROL: begin
                w_rd_word[CTRL_RX_IRQ_EN] = r_ctrl.rx_irq_en;
                w_rd_word[CTRL_TX_IRQ_EN] = r_ctrl.tx_irq_en;
            end
            default:     w_rd_word = '0;
        endcase
    end

    // ------------------------------------------------------- register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_ctrl       <= '0;
            r_sticky     <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_resp_valid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_word;
            end
            if (w_ctrl_wr) begin
                r_ctrl.rx_irq_en <= bus_interface.data_ctp[CTRL_RX_IRQ_EN];
                r_ctrl.tx_irq_en <= bus_interface.data_ctp[CTRL_TX_IRQ_EN];
            end
            // Set wins over a same-cycle clear.
            r_sticky.tx_overflow  <= (r_sticky.tx_overflow && !w_clear) || w_tx_ovf_set;
            r_sticky.rx_underflow <= (r_sticky.rx_underflow && !w_clear) || w_rx_unf_set;
            r_irq <= (r_ctrl.rx_irq_en && !w_rx_empty) || (r_ctrl.tx_irq_en && w_tx_empty);
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_bus_mailbox_target.sv
module tb_bus_mailbox_target;
    localparam int         DEPTH     = 5;
    localparam logic [7:0] BASE      = 8'h04;
    localparam logic [7:0] A_DATA    = BASE + 8'd0;
    localparam logic [7:0] A_STATUS  = BASE + 8'd1;
    localparam logic [7:0] A_CONTROL = BASE + 8'd2;
    localparam logic [7:0] A_RESV    = BASE + 8'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];   // expected read responses
    logic [31:0] tx_q[$];    // expected TX stream words
    logic [31:0] rx_m[$];    // model of RX FIFO contents
    bit          resp_due = 1'b0;

    arilla_bus_if #(.AddrWidth(8), .DataWidth(32)) bus ();

    bus_mailbox_target #(
        .BaseAddress (4),
        .Depth       (DEPTH),
        .DataWidth   (32),
        .AddrWidth   (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_interface (bus),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Read-response scoreboard: a read seen mid-cycle owes a response one
    // clock later.
    always @(negedge clk) begin
        logic [31:0] e;
        if (resp_due) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL read_data: got %h with no expected response", bus.data_ptc);
            end else begin
                e = exp_q.pop_front();
                if (bus.data_ptc !== e) $display("FAIL read_data: got %h want %h", bus.data_ptc, e);
                else n_pass++;
            end
        end
        resp_due = rst_n && bus.read && (bus.address[7:2] == BASE[7:2]);
    end

    // TX stream scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && tx_valid && tx_ready) begin
            n_checks++;
            if (tx_q.size() == 0) begin
                $display("FAIL tx_data: got %h with no expected word", tx_data);
            end else begin
                e = tx_q.pop_front();
                if (tx_data !== e) $display("FAIL tx_data: got %h want %h", tx_data, e);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.address     = a;
        bus.data_ctp    = d;
        bus.byte_enable = be;
        bus.write       = 1'b1;
        tick();
        bus.write       = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] e);
        bus.address = a;
        bus.read    = 1'b1;
        exp_q.push_back(e);
        tick();
        bus.read    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else n_pass++;
        n_checks++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b want 1", rx_ready); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        n_checks++; if (bus.hit === 1'b1) $display("FAIL idle_hit: got %b want z", bus.hit); else n_pass++;
        bus.address = A_STATUS;
        bus.read    = 1'b1;
        exp_q.push_back(32'h0000_0005);
        #1;
        n_checks++; if (bus.hit !== 1'b1) $display("FAIL window_hit: got %b want 1", bus.hit); else n_pass++;
        tick();
        bus.read = 1'b0;
        bus_read(A_CONTROL, 32'h0);
        bus_read(A_RESV, 32'h0);
        bus_write(A_RESV, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_RESV, 32'h0);
        // Outside the window: no hit, no response, no push.
        bus.address = 8'h10;
        bus.read    = 1'b1;
        #1;
        n_checks++; if (bus.hit === 1'b1) $display("FAIL outside_hit: got %b want z", bus.hit); else n_pass++;
        tick();
        bus.read = 1'b0;
        bus_write(8'h20, 32'h1234_5678, 4'hF);
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL outside_write_tx_valid: got %b want 0", tx_valid); else n_pass++;
    endtask

    task automatic test_tx_order();
        tx_ready = 1'b0;
        bus_write(A_DATA, 32'h11, 4'hF); tx_q.push_back(32'h11);
        bus_write(A_DATA, 32'h22, 4'hF); tx_q.push_back(32'h22);
        bus_write(A_DATA, 32'h33, 4'hF); tx_q.push_back(32'h33);
        bus_read(A_STATUS, 32'h0000_0304);
        tx_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL tx_drain_valid: got %b want 0", tx_valid); else n_pass++;
        tx_ready = 1'b0;
    endtask

    task automatic test_byte_lanes();
        bus_write(A_DATA, 32'hAABB_CCDD, 4'b0010); tx_q.push_back(32'h0000_CC00);
        bus_write(A_DATA, 32'hAABB_CCDD, 4'b1001); tx_q.push_back(32'hAA00_00DD);
        tx_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL lanes_drain_valid: got %b want 0", tx_valid); else n_pass++;
        tx_ready = 1'b0;
    endtask

    task automatic test_rx_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            rx_valid = 1'b1;
            rx_data  = 32'hA000 + 32'(i);
            tick();
        end
        rx_valid = 1'b0;
        n_checks++; if (rx_ready !== 1'b0) $display("FAIL rx_full_ready: got %b want 0", rx_ready); else n_pass++;
        bus_read(A_STATUS, (32'(DEPTH) << 16) | 32'h9);
        for (int i = 0; i < DEPTH; i++) bus_read(A_DATA, 32'hA000 + 32'(i));
        bus_read(A_DATA, 32'h0);
        bus_read(A_STATUS, 32'h0000_0025);
        n_checks++; if (rx_ready !== 1'b1) $display("FAIL rx_drained_ready: got %b want 1", rx_ready); else n_pass++;
    endtask

    task automatic test_overflow_flush();
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus_write(A_DATA, 32'hB000 + 32'(i), 4'hF);
            tx_q.push_back(32'hB000 + 32'(i));
        end
        bus_write(A_DATA, 32'hDEAD, 4'hF);
        n_checks++; if (tx_data !== 32'hB000) $display("FAIL full_tx_head: got %h want %h", tx_data, 32'hB000); else n_pass++;
        bus_read(A_STATUS, (32'(DEPTH) << 8) | 32'h36);
        // Byte lane 0 disabled: the whole CONTROL write is ignored.
        bus_write(A_CONTROL, 32'h1F, 4'b1110);
        bus_read(A_CONTROL, 32'h0);
        bus_read(A_STATUS, (32'(DEPTH) << 8) | 32'h36);
        bus_write(A_CONTROL, 32'h5, 4'b0001);
        tx_q.delete();
        bus_read(A_STATUS, 32'h0000_0005);
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL flush_tx_valid: got %b want 0", tx_valid); else n_pass++;
        // RX flush beats a same-cycle stream push.
        rx_valid = 1'b1;
        rx_data  = 32'h77;
        bus_write(A_CONTROL, 32'h2, 4'b0001);
        rx_valid = 1'b0;
        bus_read(A_STATUS, 32'h0000_0005);
    endtask

    task automatic test_irq();
        bus_write(A_CONTROL, 32'h08, 4'b0001);
        bus_read(A_CONTROL, 32'h08);
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_rx_empty: got %b want 0", irq); else n_pass++;
        rx_valid = 1'b1;
        rx_data  = 32'hABCD;
        tick();
        rx_valid = 1'b0;
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_lag: got %b want 0", irq); else n_pass++;
        tick();
        n_checks++; if (irq !== 1'b1) $display("FAIL irq_rx_set: got %b want 1", irq); else n_pass++;
        bus_read(A_DATA, 32'hABCD);
        n_checks++; if (irq !== 1'b1) $display("FAIL irq_pop_lag: got %b want 1", irq); else n_pass++;
        tick();
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_rx_clear: got %b want 0", irq); else n_pass++;
        bus_write(A_CONTROL, 32'h10, 4'b0001);
        tick();
        n_checks++; if (irq !== 1'b1) $display("FAIL irq_tx_empty: got %b want 1", irq); else n_pass++;
        bus_read(A_CONTROL, 32'h10);
        bus_write(A_CONTROL, 32'h00, 4'b0001);
        tick();
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_disabled: got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = 32'(i);
            rx_m.push_back(32'(i));
            tick();
        end
        // Simultaneous stream push and bus pop: occupancy stays at 3 while
        // the pointers walk past the wrap point.
        for (int i = 0; i < 4; i++) begin
            rx_data     = 32'h10 + 32'(i);
            bus.address = A_DATA;
            bus.read    = 1'b1;
            exp_q.push_back(rx_m.pop_front());
            rx_m.push_back(32'h10 + 32'(i));
            tick();
        end
        bus.read = 1'b0;
        rx_valid = 1'b0;
        bus_read(A_STATUS, 32'h0003_0001);
        while (rx_m.size() > 0) bus_read(A_DATA, rx_m.pop_front());
        bus_read(A_STATUS, 32'h0000_0005);
        // Back-to-back TX writes with the consumer always ready.
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_write(A_DATA, 32'hC0 + 32'(i), 4'hF);
            tx_q.push_back(32'hC0 + 32'(i));
        end
        tick();
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL b2b_tx_valid: got %b want 0", tx_valid); else n_pass++;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        bus_write(A_CONTROL, 32'h18, 4'b0001);
        rx_valid = 1'b1;
        rx_data  = 32'h1234;
        tick();
        rx_valid = 1'b0;
        bus_write(A_DATA, 32'h55, 4'hF);
        tick();
        n_checks++; if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b want 1", irq); else n_pass++;
        rst_n       = 1'b0;
        bus.address = A_DATA;
        bus.read    = 1'b1;
        tick();
        bus.read = 1'b0;
        rst_n    = 1'b1;
        tx_q.delete();
        n_checks++;
        if ((bus.data_ptc !== {32{1'bz}}) && (bus.data_ptc !== 32'h0))
            $display("FAIL abandoned_resp: got %h want z", bus.data_ptc);
        else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", tx_valid); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else n_pass++;
        bus_read(A_STATUS, 32'h0000_0005);
        bus_read(A_CONTROL, 32'h0);
    endtask

    initial begin
        bus.address     = '0;
        bus.byte_enable = '0;
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.data_ctp    = '0;

        test_reset();
        test_tx_order();
        test_byte_lanes();
        test_rx_fill_drain();
        test_overflow_flush();
        test_irq();
        test_back_to_back();
        test_reset_mid_read();

        repeat (2) tick();
        n_checks++; if (exp_q.size() != 0) $display("FAIL pending_reads: got %0d want 0", exp_q.size()); else n_pass++;
        n_checks++; if (tx_q.size() != 0) $display("FAIL pending_tx: got %0d want 0", tx_q.size()); else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
